// File: rtl/bcd_tick_counter.sv
// Multi-digit BCD tick counter with clear, saturating-to-9 parallel load and a wrap pulse.
// Define BCD_COUNTER_DOWN_EN to add the up_i port and down counting with borrow wrap.
module bcd_tick_counter #(
   parameter int DIGITS_N = 4
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  tick_i,
   input  logic                  enable_i,
   input  logic                  clear_i,
   input  logic                  load_i,
   input  logic [4*DIGITS_N-1:0] load_value_i,
`ifdef BCD_COUNTER_DOWN_EN
   input  logic                  up_i,
`endif
   output logic [4*DIGITS_N-1:0] digits_o,
   output logic                  wrap_o,
   output logic                  zero_o
);

   logic [4*DIGITS_N-1:0] digits_q, digits_d;
   logic                  wrap_q, wrap_d;
   logic [4*DIGITS_N-1:0] count_val;
   logic [4*DIGITS_N-1:0] load_clamped;
   // carry[i] means digit i must step; carry[DIGITS_N] is the wrap out of the top digit
   logic [DIGITS_N:0]     carry;

   assign carry[0] = 1'b1;

   generate
      for (genvar gi = 0; gi < DIGITS_N; gi++) begin : g_digit
         logic [3:0] cur;
         logic [3:0] nib;
         assign cur = digits_q[4*gi +: 4];
         assign nib = load_value_i[4*gi +: 4];
         assign load_clamped[4*gi +: 4] = (nib > 4'd9) ? 4'd9 : nib;
`ifdef BCD_COUNTER_DOWN_EN
         assign carry[gi+1] = carry[gi] && (up_i ? (cur == 4'd9) : (cur == 4'd0));
         always_comb begin
            count_val[4*gi +: 4] = cur;
            if (carry[gi]) begin
               if (up_i)
                  count_val[4*gi +: 4] = (cur == 4'd9) ? 4'd0 : cur + 4'd1;
               else
                  count_val[4*gi +: 4] = (cur == 4'd0) ? 4'd9 : cur - 4'd1;
            end
         end
`else
         assign carry[gi+1] = carry[gi] && (cur == 4'd9);
         always_comb begin
            count_val[4*gi +: 4] = cur;
            if (carry[gi])
               count_val[4*gi +: 4] = (cur == 4'd9) ? 4'd0 : cur + 4'd1;
         end
`endif
      end
   endgenerate

   // A tick coinciding with clear or load is dropped, not deferred.
   always_comb begin
      digits_d = digits_q;
      wrap_d   = 1'b0;
      if (clear_i) begin
         digits_d = '0;
      end else if (load_i) begin
         digits_d = load_clamped;
      end else if (tick_i && enable_i) begin
         digits_d = count_val;
         wrap_d   = carry[DIGITS_N];
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         digits_q <= '0;
         wrap_q   <= 1'b0;
      end else begin
         digits_q <= digits_d;
         wrap_q   <= wrap_d;
      end
   end

   assign digits_o = digits_q;
   assign wrap_o   = wrap_q;
   assign zero_o   = (digits_q == '0);

endmodule
